// File: rtl/chunk_inner_loop.sv
// chunk_inner_loop: SHA-256 compression of one padded chunk, one round per clock.
// Define CHUNK_INNER_LOOP_CHAIN_EN to take the initial hash from hash_in.
module chunk_inner_loop (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] chunk,
  input  logic         valid,
`ifdef CHUNK_INNER_LOOP_CHAIN_EN
  input  logic [255:0] hash_in,
`endif
  output logic [255:0] hash,
  output logic         ready
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(
    input logic [31:0] x,
    input int          n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t      state;
  logic [5:0]  t;
  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] w [16];
  logic [31:0] t1, t2, wn;
  logic [255:0] hinit;
  logic [255:0] hload;
  logic [255:0] fin;

`ifdef CHUNK_INNER_LOOP_CHAIN_EN
  assign hload = hash_in;
`else
  assign hinit = H0;
  assign hload = H0;
`endif

  assign t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + K[t] + w[0];
  assign t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
  assign wn = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];

  assign fin = {
    hinit[255:224] + a, hinit[223:192] + b,
    hinit[191:160] + c, hinit[159:128] + d,
    hinit[127:96]  + e, hinit[95:64]   + f,
    hinit[63:32]   + g, hinit[31:0]    + h
  };

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b1;
      hash  <= '0;
      t     <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
`ifdef CHUNK_INNER_LOOP_CHAIN_EN
      hinit <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (valid) begin
            for (int i = 0; i < 16; i++)
              w[i] <= chunk[511 - 32*i -: 32];
            {a, b, c, d, e, f, g, h} <= hload;
`ifdef CHUNK_INNER_LOOP_CHAIN_EN
            hinit <= hash_in;
`endif
            t     <= '0;
            ready <= 1'b0;
            state <= ROUND;
          end
        end
        ROUND: begin
          h <= g;
          g <= f;
          f <= e;
          e <= d + t1;
          d <= c;
          c <= b;
          b <= a;
          a <= t1 + t2;
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= wn;
          t <= t + 6'd1;
          if (t == 6'd63) state <= FINAL;
        end
        FINAL: begin
          hash  <= fin;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_inner_loop.sv
// tb_chunk_inner_loop: known-answer SHA-256 vectors with a digest scoreboard.
// Covers reset, latency, busy-ignore, mid-run abort and back-to-back jobs.
module tb_chunk_inner_loop;

  localparam logic [511:0] C_HELLO =
    {96'h68656c6c6f20776f726c6480, 352'h0, 64'h58};
  localparam logic [511:0] C_ABC =
    {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] C_EMPTY =
    {8'h80, 504'h0};

  localparam logic [255:0] D_HELLO =
    256'hB94D27B9934D3E08A52E52D7DA7DABFAC484EFE37A5380EE9088F7ACE2EFCDE9;
  localparam logic [255:0] D_ABC =
    256'hBA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD;
  localparam logic [255:0] D_EMPTY =
    256'hE3B0C44298FC1C149AFBF4C8996FB92427AE41E4649B934CA495991B7852B855;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid;
  logic [511:0] chunk;
  logic [255:0] hash;
  logic         ready;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [255:0] q [$];
  logic [255:0] last_hash;

`ifdef CHUNK_INNER_LOOP_CHAIN_EN
  logic [255:0] hash_in;
  assign hash_in = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
`endif

  chunk_inner_loop dut (
    .clk     (clk),
    .reset   (reset),
    .chunk   (chunk),
    .valid   (valid),
`ifdef CHUNK_INNER_LOOP_CHAIN_EN
    .hash_in (hash_in),
`endif
    .hash    (hash),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble;
    for (int i = 0; i < 16; i++) chunk[i*32 +: 32] = $urandom;
  endtask

  task automatic start(input logic [511:0] c, input logic [255:0] exp);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ready: got %b want 1", ready);
    end
    valid = 1'b1;
    chunk = c;
    q.push_back(exp);
    step;
    valid = 1'b0;
    scramble;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_ready: got %b want 0", ready);
    end
  endtask

  task automatic wait_done(input string name, input int inj);
    int           cnt;
    bit           held;
    logic [255:0] exp;
    cnt  = 0;
    held = 1'b1;
    while (ready !== 1'b1 && cnt < 200) begin
      if (hash !== last_hash) held = 1'b0;
      if (cnt == inj) begin
        valid = 1'b1;
        chunk = C_HELLO;
      end else begin
        valid = 1'b0;
      end
      step;
      cnt++;
    end
    valid = 1'b0;
    n_checks++;
    if (cnt != 65) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles want 65", name, cnt);
    end
    n_checks++;
    if (!held) begin
      n_fail++;
      $display("FAIL %s_hold: hash changed while busy, want %h", name, last_hash);
    end
    exp = '0;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_scoreboard: got empty queue want one entry", name);
    end else begin
      exp = q.pop_front();
    end
    n_checks++;
    if (hash !== exp) begin
      n_fail++;
      $display("FAIL %s_digest: got %h want %h", name, hash, exp);
    end
    last_hash = exp;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    valid = 1'b0;
    chunk = '0;
    step;
    step;
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", ready);
    end
    n_checks++;
    if (hash !== '0) begin
      n_fail++;
      $display("FAIL reset_hash: got %h want 0", hash);
    end
    reset = 1'b0;
    step;
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready: got %b want 1", ready);
    end
    last_hash = '0;
  endtask

  task automatic test_vectors;
    start(C_HELLO, D_HELLO);
    wait_done("hello", -1);
    step;
    start(C_ABC, D_ABC);
    wait_done("abc", -1);
    step;
    start(C_EMPTY, D_EMPTY);
    wait_done("empty", -1);
    step;
  endtask

  task automatic test_busy_ignore;
    start(C_ABC, D_ABC);
    wait_done("busy", 10);
    step;
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after: got ready %b want 1", ready);
    end
  endtask

  task automatic test_reset_mid;
    bit clean;
    start(C_HELLO, D_HELLO);
    repeat (29) step;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_busy: got ready %b want 0", ready);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (ready !== 1'b1 || hash !== '0) begin
      n_fail++;
      $display("FAIL mid_async: got ready %b hash %h want 1 and 0", ready, hash);
    end
    q.delete();
    last_hash = '0;
    step;
    reset = 1'b0;
    clean = 1'b1;
    repeat (70) begin
      if (ready !== 1'b1 || hash !== '0) clean = 1'b0;
      step;
    end
    n_checks++;
    if (!clean) begin
      n_fail++;
      $display("FAIL mid_no_partial: got ready %b hash %h want 1 and 0", ready, hash);
    end
    start(C_HELLO, D_HELLO);
    wait_done("after_abort", -1);
    step;
  endtask

  task automatic test_reset_valid;
    reset = 1'b1;
    valid = 1'b1;
    chunk = C_ABC;
    step;
    reset = 1'b0;
    valid = 1'b0;
    step;
    n_checks++;
    if (ready !== 1'b1 || hash !== '0) begin
      n_fail++;
      $display("FAIL reset_wins: got ready %b hash %h want 1 and 0", ready, hash);
    end
    last_hash = '0;
  endtask

  task automatic test_back_to_back;
    start(C_HELLO, D_HELLO);
    wait_done("b2b_hello", -1);
    start(C_ABC, D_ABC);
    wait_done("b2b_abc", -1);
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_busy_ignore;
    test_reset_mid;
    test_reset_valid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
